serial_addend_recover: RTL and testbench
========================================

// Module: serial_addend_recover
// PURPOSE
//  Inverse of the 2-bit adder-slice arithmetic in the lgsynth91 benchmark set: given an adder result
//  {cout,sum}, the known addend b and the carry-in cin, recovers the other operand
//  a = {cout,sum} - b - cin. Operates bit-serially, LSB first, with a one-bit borrow register.
//  Uses valid/ready handshakes on both sides. Sits downstream of adder-slice
//  benchmarks as a checker/decoder stage.
// PARAMETERS
//  WIDTH  2  operand width in bits; legal range 1..32
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      input word valid
//  in_ready   out  1      block can accept a word; high only in IDLE
//  in_sum     in   WIDTH  adder sum bits
//  in_cout    in   1      adder carry-out
//  in_b       in   WIDTH  known addend
//  in_cin     in   1      adder carry-in
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_a      out  WIDTH  recovered operand, modulo 2^WIDTH
//  out_err    out  1      1 = {cout,sum}-b-cin lies outside [0, 2^WIDTH)
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid=0; out_a=0; out_err=0; borrow=0; bit index=0.
//  - FSM states IDLE, BUSY, DONE.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid: latch sum, b and cout.
//    - Set borrow=in_cin and idx=0; go to BUSY.
//  - BUSY (exactly WIDTH cycles): on each edge, for i=idx:
//    - a[i] = s[i]^b[i]^borrow
//    - borrow' = (~s[i]&b[i]) | (~s[i]&borrow) | (b[i]&borrow)
//    - idx increments.
//    - At idx=WIDTH-1, go to DONE.
//    - out_a is shifted/assembled internally and is not updated on the port until DONE.
//  - Entering DONE:
//    - out_a = assembled a.
//    - out_err = final_borrow ^ cout.
//    - out_valid=1.
//  - DONE:
//    - out_valid, out_a and out_err are held stable while out_ready=0.
//    - On out_ready=1: out_valid=0 next cycle; go to IDLE.
//  - Latency: word accepted at edge k -> out_valid high from edge k+WIDTH.
//  - Throughput: one word per WIDTH+2 cycles minimum. in_ready=0 in BUSY and DONE,
//    so a new word is never accepted in the same cycle as a result handoff.
//  - in_valid while in_ready=0: ignored; the source must hold the word.
//  - rst has priority over everything:
//    - Mid-BUSY or mid-DONE, the word in flight is discarded and all outputs return to reset values.
//    - No partial result ever appears on out_a.
//  - Arithmetic:
//    - Borrow chain is WIDTH bits; no internal widening.
//    - out_err=1 exactly when the true difference is negative or >= 2^WIDTH.
//    - out_a is then the difference mod 2^WIDTH.
// TESTING
//  1 Directed, WIDTH=2: sum=2'b10, cout=1, b=3, cin=1 -> out_a=2, out_err=0.
//    out_valid rises 2 cycles after acceptance.
//  2 Underflow, WIDTH=2: sum=0, cout=0, b=1, cin=0 -> out_a=3, out_err=1.
//    Overflow: sum=3, cout=1, b=0, cin=0 -> out_a=3, out_err=1.
//  3 Exhaustive, WIDTH=2: all 32 (a,b,cin) combinations are driven through a golden adder model
//    into the inputs -> out_a==a and out_err=0 for every case.
//  4 Backpressure: hold out_ready=0 for 5 cycles in DONE.
//    -> out_a/out_err/out_valid stable; in_ready=0; an in_valid pulse meanwhile is not accepted.
//  5 Reset mid-op: assert rst for 1 cycle on the 2nd BUSY cycle, WIDTH=8.
//    -> next cycle IDLE, in_ready=1, out_valid=0, out_a=0.
//    A following word then computes correctly.
//  6 WIDTH=8: sum=8'h05, cout=1, b=8'hFF, cin=1 -> out_a=8'h05, out_err=0, latency 8.

Source files
------------

// File: rtl/serial_addend_recover.sv
// Bit-serial inverse of an adder slice: recovers a = {cout,sum} - b - cin, LSB first,
// through a one-bit borrow register, with valid/ready handshakes on both sides.
module serial_addend_recover #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic             out_err
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cout_q, cout_d;
    logic             borrow_q, borrow_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic             out_err_q, out_err_d;

    logic abit, bnext;

    // One full-subtractor slice on the current bit.
    assign abit  = s_q[idx_q] ^ b_q[idx_q] ^ borrow_q;
    assign bnext = (~s_q[idx_q] & b_q[idx_q]) | (~s_q[idx_q] & borrow_q) | (b_q[idx_q] & borrow_q);

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        b_d       = b_q;
        cout_d    = cout_q;
        borrow_d  = borrow_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        out_a_d   = out_a_q;
        out_err_d = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d      = in_sum;
                    b_d      = in_b;
                    cout_d   = in_cout;
                    borrow_d = in_cin;
                    idx_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d[idx_q] = abit;
                borrow_d     = bnext;
                idx_d        = idx_q + IDXW'(1);
                if (idx_q == LAST) begin
                    // Result is in range only when the final borrow cancels the carry-out.
                    out_a_d   = acc_d;
                    out_err_d = bnext ^ cout_q;
                    idx_d     = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s_q       <= '0;
            b_q       <= '0;
            cout_q    <= 1'b0;
            borrow_q  <= 1'b0;
            idx_q     <= '0;
            acc_q     <= '0;
            out_a_q   <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            b_q       <= b_d;
            cout_q    <= cout_d;
            borrow_q  <= borrow_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            out_a_q   <= out_a_d;
            out_err_q <= out_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_a     = out_a_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_serial_addend_recover.sv
// Self-checking bench for serial_addend_recover at WIDTH=2 and WIDTH=8 against an
// integer-arithmetic model of {cout,sum} - b - cin.
module tb_serial_addend_recover;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=2 instance
    logic       rst2 = 1'b1, in_valid2 = 1'b0, out_ready2 = 1'b0;
    logic [1:0] in_sum2 = '0, in_b2 = '0;
    logic       in_cout2 = 1'b0, in_cin2 = 1'b0;
    logic       in_ready2, out_valid2, out_err2;
    logic [1:0] out_a2;

    // WIDTH=8 instance
    logic       rst8 = 1'b1, in_valid8 = 1'b0, out_ready8 = 1'b0;
    logic [7:0] in_sum8 = '0, in_b8 = '0;
    logic       in_cout8 = 1'b0, in_cin8 = 1'b0;
    logic       in_ready8, out_valid8, out_err8;
    logic [7:0] out_a8;

    serial_addend_recover #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_sum(in_sum2), .in_cout(in_cout2), .in_b(in_b2), .in_cin(in_cin2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_a(out_a2), .out_err(out_err2)
    );

    serial_addend_recover #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_sum(in_sum8), .in_cout(in_cout8), .in_b(in_b8), .in_cin(in_cin8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_a(out_a8), .out_err(out_err8)
    );

    function automatic void model(input int w, input int sum, input int cout, input int b,
                                  input int cin, output int a, output int err);
        int d;
        d   = cout * (1 << w) + sum - b - cin;
        err = (d < 0 || d >= (1 << w)) ? 1 : 0;
        a   = d & ((1 << w) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word, wait for it to be accepted, then count cycles until out_valid.
    task automatic run2(input int sum, input int cout, input int b, input int cin, output int lat);
        in_sum2 = sum[1:0]; in_cout2 = cout[0]; in_b2 = b[1:0]; in_cin2 = cin[0];
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run8(input int sum, input int cout, input int b, input int cin, output int lat);
        in_sum8 = sum[7:0]; in_cout8 = cout[0]; in_b8 = b[7:0]; in_cin8 = cin[0];
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic take2();
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
    endtask

    task automatic take8();
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        rst2 = 1'b1; rst8 = 1'b1;
        tick(); tick();
        rst2 = 1'b0; rst8 = 1'b0;
        checks++;
        if ({in_ready2, out_valid2, out_a2, out_err2} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_w2: got rdy=%b vld=%b a=%h err=%b want 1 0 0 0",
                     in_ready2, out_valid2, out_a2, out_err2);
        end
        checks++;
        if ({in_ready8, out_valid8, out_a8, out_err8} !== 11'b10_00000000_0) begin
            errors++;
            $display("FAIL reset_w8: got rdy=%b vld=%b a=%h err=%b want 1 0 0 0",
                     in_ready8, out_valid8, out_a8, out_err8);
        end
    endtask

    task automatic test_directed();
        int lat;
        run2(2, 1, 3, 1, lat);
        checks++;
        if (lat !== 2 || out_a2 !== 2'd2 || out_err2 !== 1'b0) begin
            errors++;
            $display("FAIL directed_w2: got lat=%0d a=%0d err=%b want lat=2 a=2 err=0", lat, out_a2, out_err2);
        end
        take2();
        checks++;
        if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL handoff_w2: got vld=%b rdy=%b want 0 1", out_valid2, in_ready2);
        end
    endtask

    task automatic test_range_err();
        int lat;
        run2(0, 0, 1, 0, lat);
        checks++;
        if (out_a2 !== 2'd3 || out_err2 !== 1'b1) begin
            errors++;
            $display("FAIL underflow_w2: got a=%0d err=%b want a=3 err=1", out_a2, out_err2);
        end
        take2();
        run2(3, 1, 0, 0, lat);
        checks++;
        if (out_a2 !== 2'd3 || out_err2 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_w2: got a=%0d err=%b want a=3 err=1", out_a2, out_err2);
        end
        take2();
    endtask

    task automatic test_exhaustive();
        int lat, tot;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++) begin
                    tot = a + b + c;
                    run2(tot & 3, tot >> 2, b, c, lat);
                    checks++;
                    if (lat !== 2 || out_a2 !== a[1:0] || out_err2 !== 1'b0) begin
                        errors++;
                        $display("FAIL exhaustive_w2 a=%0d b=%0d cin=%0d: got lat=%0d a=%0d err=%b want lat=2 a=%0d err=0",
                                 a, b, c, lat, out_a2, out_err2, a);
                    end
                    take2();
                end
    endtask

    task automatic test_random2();
        int lat, s, co, b, ci, ea, ee;
        for (int n = 0; n < 20; n++) begin
            s = int'($urandom_range(0, 3)); co = int'($urandom_range(0, 1));
            b = int'($urandom_range(0, 3)); ci = int'($urandom_range(0, 1));
            model(2, s, co, b, ci, ea, ee);
            run2(s, co, b, ci, lat);
            checks++;
            if (out_a2 !== ea[1:0] || out_err2 !== ee[0]) begin
                errors++;
                $display("FAIL random_w2 s=%0d co=%0d b=%0d ci=%0d: got a=%0d err=%b want a=%0d err=%0d",
                         s, co, b, ci, out_a2, out_err2, ea, ee);
            end
            take2();
        end
    endtask

    task automatic test_backpressure();
        int lat, ea, ee;
        model(2, 1, 1, 2, 0, ea, ee);
        run2(1, 1, 2, 0, lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_sum2 = 2'd3; in_b2 = 2'd0; in_cout2 = 1'b0; in_cin2 = 1'b0;
                in_valid2 = 1'b1;
            end
            checks++;
            if (out_valid2 !== 1'b1 || in_ready2 !== 1'b0 || out_a2 !== ea[1:0] || out_err2 !== ee[0]) begin
                errors++;
                $display("FAIL backpressure_w2 cyc=%0d: got vld=%b rdy=%b a=%0d err=%b want 1 0 %0d %0d",
                         i, out_valid2, in_ready2, out_a2, out_err2, ea, ee);
            end
            tick();
            in_valid2 = 1'b0;
        end
        take2();
        // The word pulsed during DONE must not have started a computation.
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
                errors++;
                $display("FAIL ignored_pulse_w2 cyc=%0d: got vld=%b rdy=%b want 0 1", i, out_valid2, in_ready2);
            end
            tick();
        end
    endtask

    task automatic test_w8();
        int lat, s, co, b, ci, ea, ee;
        run8(8'h05, 1, 8'hFF, 1, lat);
        checks++;
        if (lat !== 8 || out_a8 !== 8'h05 || out_err8 !== 1'b0) begin
            errors++;
            $display("FAIL directed_w8: got lat=%0d a=%h err=%b want lat=8 a=05 err=0", lat, out_a8, out_err8);
        end
        take8();
        for (int n = 0; n < 25; n++) begin
            s = int'($urandom_range(0, 255)); co = int'($urandom_range(0, 1));
            b = int'($urandom_range(0, 255)); ci = int'($urandom_range(0, 1));
            model(8, s, co, b, ci, ea, ee);
            run8(s, co, b, ci, lat);
            checks++;
            if (lat !== 8 || out_a8 !== ea[7:0] || out_err8 !== ee[0]) begin
                errors++;
                $display("FAIL random_w8 s=%h co=%0d b=%h ci=%0d: got lat=%0d a=%h err=%b want lat=8 a=%h err=%0d",
                         s, co, b, ci, lat, out_a8, out_err8, ea[7:0], ee);
            end
            take8();
        end
    endtask

    task automatic test_reset_mid();
        int lat, ea, ee;
        // Leave a nonzero result on the port first so the reset has something to clear.
        run8(8'hA0, 0, 8'h10, 0, lat);
        take8();
        in_sum8 = 8'h33; in_cout8 = 1'b0; in_b8 = 8'h11; in_cin8 = 1'b1;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || out_a8 !== 8'h00 || out_err8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_w8: got rdy=%b vld=%b a=%h err=%b want 1 0 00 0",
                     in_ready8, out_valid8, out_a8, out_err8);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid8 !== 1'b0) begin
                errors++;
                $display("FAIL reset_discard_w8 cyc=%0d: got vld=%b want 0", i, out_valid8);
            end
            tick();
        end
        model(8, 8'h7E, 1, 8'h9C, 1, ea, ee);
        run8(8'h7E, 1, 8'h9C, 1, lat);
        checks++;
        if (lat !== 8 || out_a8 !== ea[7:0] || out_err8 !== ee[0]) begin
            errors++;
            $display("FAIL after_reset_w8: got lat=%0d a=%h err=%b want lat=8 a=%h err=%0d",
                     lat, out_a8, out_err8, ea[7:0], ee);
        end
        take8();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_range_err();
        test_exhaustive();
        test_random2();
        test_backpressure();
        test_w8();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
